// File: rtl/bsg_dmc_clk_init_seq.sv
// bsg_dmc_clk_init_seq: walks the DMC clock/reset bring-up command list over a valid/yumi tag port (start_i, osc/ds/dly values in; cmd_v/id/data out, cmd_yumi_i in; busy_o, done_o status)
module bsg_dmc_clk_init_seq #(
  parameter int dq_group_p = 4,
  parameter int data_width_p = 16,
  parameter int settle_cycles_p = 64,
  parameter int lock_cycles_p = 1024,
  localparam int id_width_lp = $clog2(8+2*dq_group_p),
  localparam int max_cnt_lp = settle_cycles_p > lock_cycles_p ? settle_cycles_p : lock_cycles_p,
  localparam int cnt_width_lp = max_cnt_lp == 0 ? 1 : $clog2(max_cnt_lp+1),
  localparam int n_cmd_lp = 9+3*dq_group_p,
  localparam int step_width_lp = $clog2(n_cmd_lp)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             start_i,
  input  logic [data_width_p-1:0]          osc_val_i,
  input  logic [data_width_p-1:0]          ds_val_i,
  input  logic [dq_group_p*data_width_p-1:0] dly_val_i,
  output logic                             cmd_v_o,
  output logic [id_width_lp-1:0]           cmd_id_o,
  output logic [data_width_p-1:0]          cmd_data_o,
  input  logic                             cmd_yumi_i,
  output logic                             busy_o,
  output logic                             done_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SETTLE, WAIT_LOCK, DONE} state_e;
  localparam logic [step_width_lp-1:0] k4_lp = step_width_lp'(4);
  localparam logic [step_width_lp-1:0] last_lp = step_width_lp'(n_cmd_lp-1);
  state_e state_r;
  logic [step_width_lp-1:0] step_r, step_n;
  logic [cnt_width_lp-1:0] cnt_r;
  logic [data_width_p-1:0] osc_r;
  logic [data_width_p-2:0] ds_r;
  logic [dq_group_p*data_width_p-1:0] dly_r;
  logic unused_ds_msb;
  assign unused_ds_msb = ds_val_i[data_width_p-1];
  assign step_n = step_r + step_width_lp'(1);
  function automatic logic [id_width_lp+data_width_p-1:0] decode(input logic [step_width_lp-1:0] k);
    int id, j, g;
    logic [data_width_p-1:0] d;
    id = 4;
    d = '0;
    j = int'(k) - 8;
    g = j / 3;
    case (int'(k))
      0: begin id = 0; d[0] = 1'b1; end
      1: begin id = 1; d = osc_r; end
      2: begin id = 2; d[0] = 1'b1; end
      3: id = 2;
      4: id = 0;
      5: begin id = 3; d = {ds_r, 1'b1}; end
      6: begin id = 3; d = {ds_r, 1'b0}; end
      7: begin id = 4; d[0] = 1'b1; end
      default: if (int'(k) < n_cmd_lp-1) begin
        id = 8 + 2*g + (j % 3 != 0 ? 1 : 0);
        d = (j % 3 == 0) ? dly_r[g*data_width_p +: data_width_p] : data_width_p'(j % 3 == 1);
      end
    endcase
    return {id_width_lp'(id), d};
  endfunction
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_r <= IDLE;
      step_r <= '0;
      cnt_r <= '0;
      osc_r <= '0;
      ds_r <= '0;
      dly_r <= '0;
      cmd_v_o <= 1'b0;
      cmd_id_o <= '0;
      cmd_data_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else case (state_r)
      IDLE, DONE: if (start_i) begin
        state_r <= ISSUE;
        step_r <= '0;
        osc_r <= osc_val_i;
        ds_r <= ds_val_i[data_width_p-2:0];
        dly_r <= dly_val_i;
        cmd_v_o <= 1'b1;
        {cmd_id_o, cmd_data_o} <= decode('0);
        busy_o <= 1'b1;
        done_o <= 1'b0;
      end
      ISSUE: if (cmd_yumi_i && cmd_v_o) begin
        step_r <= step_n;
        {cmd_id_o, cmd_data_o} <= decode(step_n);
        if (step_r == k4_lp || step_r == last_lp) begin
          cmd_v_o <= 1'b0;
          state_r <= step_r == k4_lp ? WAIT_SETTLE : WAIT_LOCK;
          cnt_r <= step_r == k4_lp ? cnt_width_lp'(settle_cycles_p) : cnt_width_lp'(lock_cycles_p);
        end
      end
      WAIT_SETTLE, WAIT_LOCK: if (cnt_r == '0) begin
        state_r <= state_r == WAIT_SETTLE ? ISSUE : DONE;
        cmd_v_o <= state_r == WAIT_SETTLE;
        busy_o <= state_r == WAIT_SETTLE;
        done_o <= state_r == WAIT_LOCK;
      end else cnt_r <= cnt_r - cnt_width_lp'(1);
      default: state_r <= IDLE;
    endcase
  assert property (@(posedge clk_i) disable iff (reset_i) cmd_yumi_i |-> cmd_v_o);
endmodule

// File: tb/tb_bsg_dmc_clk_init_seq.sv
// tb_bsg_dmc_clk_init_seq: scoreboard bench checking the bring-up sequence against a list-building model
module tb_bsg_dmc_clk_init_seq;
  localparam int G = 4, W = 16, N = 9 + 3*G;
  localparam int S0 = 64, L0 = 1024, S1 = 0, L1 = 0;
  typedef struct {int id; logic [W-1:0] d; int k;} cmd_t;
  logic clk_i = 1'b0, reset_i = 1'b1, start_i = 1'b0, sel = 1'b0, yumi = 1'b0;
  logic [W-1:0] osc_val_i = '0, ds_val_i = '0;
  logic [G*W-1:0] dly_val_i = '0;
  logic v0, v1, busy0, busy1, done0, done1, v, busy, done;
  logic [3:0] id0, id1, id;
  logic [W-1:0] d0, d1, d;
  cmd_t q[$];
  int n_pass = 0, n_chk = 0, cyc = 0, nk = 0, n_acc = 0, stall = 0, stall_mode = 0, tied = 0;
  int t_start = 0, k4_acc = 0, fin_acc = 0;
  logic hs = 1'b0, prev_v = 1'b0, prev_done = 1'b0;
  logic [3:0] prev_id = '0;
  logic [W-1:0] prev_d = '0;
  bsg_dmc_clk_init_seq #(.dq_group_p(G), .data_width_p(W), .settle_cycles_p(S0), .lock_cycles_p(L0)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i & !sel), .osc_val_i(osc_val_i), .ds_val_i(ds_val_i),
    .dly_val_i(dly_val_i), .cmd_v_o(v0), .cmd_id_o(id0), .cmd_data_o(d0), .cmd_yumi_i(yumi & !sel),
    .busy_o(busy0), .done_o(done0));
  bsg_dmc_clk_init_seq #(.dq_group_p(G), .data_width_p(W), .settle_cycles_p(S1), .lock_cycles_p(L1)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i & sel), .osc_val_i(osc_val_i), .ds_val_i(ds_val_i),
    .dly_val_i(dly_val_i), .cmd_v_o(v1), .cmd_id_o(id1), .cmd_data_o(d1), .cmd_yumi_i(yumi & sel),
    .busy_o(busy1), .done_o(done1));
  assign v = sel ? v1 : v0;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign id = sel ? id1 : id0;
  assign d = sel ? d1 : d0;
  always #5 clk_i = ~clk_i;
  initial forever @(posedge clk_i) cyc++;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic push(input int cid, input logic [W-1:0] cd);
    q.push_back('{cid, cd, nk});
    nk++;
  endtask
  task automatic load_model(input logic [W-1:0] osc, input logic [W-1:0] ds, input logic [G*W-1:0] dly);
    nk = 0;
    push(0, 1); push(1, osc); push(2, 1); push(2, 0); push(0, 0);
    push(3, {ds[W-2:0], 1'b1}); push(3, {ds[W-2:0], 1'b0}); push(4, 1);
    for (int g = 0; g < G; g++) begin
      push(8 + 2*g, dly[g*W +: W]);
      push(9 + 2*g, 1);
      push(9 + 2*g, 0);
    end
    push(4, 0);
  endtask
  task automatic do_start(input logic [W-1:0] osc, input logic [W-1:0] ds, input logic [G*W-1:0] dly);
    osc_val_i = osc;
    ds_val_i = ds;
    dly_val_i = dly;
    start_i = 1'b1;
    n_acc = 0;
    load_model(osc, ds, dly);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    t_start = cyc;
    chk("start_busy", busy, 1);
    chk("start_valid", v, 1);
    chk("start_done_clear", done, 0);
    osc_val_i = ~osc;
    ds_val_i = W'($urandom);
    dly_val_i = ~dly;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 3000 && !done; i++) begin @(posedge clk_i); #1; end
    chk("done_reached", done, 1);
    chk("done_queue_empty", q.size(), 0);
  endtask
  task automatic wait_acc(input int n);
    for (int i = 0; i < 3000 && n_acc < n; i++) begin @(posedge clk_i); #1; end
    chk("accept_count_reached", n_acc >= n, 1);
  endtask
  function automatic logic [G*W-1:0] rnd_dly();
    return {$urandom, $urandom};
  endfunction
  initial forever begin
    cmd_t e;
    @(negedge clk_i);
    if (hs) stall = stall_mode != 0 ? int'($urandom_range(5, 0)) : 0;
    if (v && stall != 0) begin yumi = 1'b0; stall--; end else yumi = v;
    if (v && prev_v && !hs) begin
      chk("hold_id", id, prev_id);
      chk("hold_data", d, prev_d);
    end
    if (v && (!prev_v || hs) && q.size() != 0 && q[0].k == 5) chk("settle_gap", cyc - k4_acc, (sel ? S1 : S0) + 1);
    if (done && !prev_done) begin
      chk("lock_gap", cyc - fin_acc, (sel ? L1 : L0) + 1);
      chk("done_busy_low", busy, 0);
      if (tied != 0) chk("total_length", cyc - t_start, N + (sel ? S1 + L1 : S0 + L0) + 2);
    end
    prev_v = v;
    prev_id = id;
    prev_d = d;
    prev_done = done;
    hs = yumi && !reset_i;
    if (hs) begin
      chk("cmd_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk($sformatf("cmd%0d_id", e.k), id, e.id);
        chk($sformatf("cmd%0d_data", e.k), d, e.d);
        chk("busy_during_cmd", busy, 1);
        if (e.k == 4) k4_acc = cyc + 1;
        if (e.k == N - 1) fin_acc = cyc + 1;
        n_acc++;
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_v", v, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_id", id, 0);
    chk("reset_data", d, 0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    tied = 1;
    do_start(16'h5A, W'($urandom), {16'h3, 16'h7, 16'h1, 16'h9});
    wait_done();
    tied = 0;
    stall_mode = 1;
    do_start(W'($urandom), W'($urandom), rnd_dly());
    wait_acc(5);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("start_ignored_in_settle", v, 0);
    wait_done();
    do_start(W'($urandom), W'($urandom), rnd_dly());
    wait_acc(14);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk("abort_v", v, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset_i = 1'b0;
    q.delete();
    @(posedge clk_i); #1;
    chk("abort_stays_idle", v, 0);
    do_start(W'($urandom), W'($urandom), rnd_dly());
    wait_done();
    stall_mode = 0;
    tied = 1;
    sel = 1'b1;
    @(posedge clk_i); #1;
    do_start(W'($urandom), W'($urandom), rnd_dly());
    wait_done();
    tied = 0;
    stall_mode = 1;
    do_start(W'($urandom), W'($urandom), rnd_dly());
    wait_done();
    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
